// File: rtl/ir_scan_seq.sv
// Round-robin sequencer for NUM_PAIRS left/right IR sensor pairs sharing one A2D.
// Builds a weighted, signed line-position error and publishes it with a one-cycle err_vld pulse.
module ir_scan_seq #(
    parameter int NUM_PAIRS   = 3,
    parameter int RES_W       = 12,
    parameter int CHNL_W      = 3,
    parameter int SETTLE_CYC  = 4096,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              scan,
    input  logic                              cont,
    input  logic [NUM_PAIRS-1:0]              pair_mask,
    input  logic                              cnv_cmplt,
    input  logic [RES_W-1:0]                  A2D_res,
    output logic                              strt_cnv,
    output logic [CHNL_W-1:0]                 chnnl,
    output logic [NUM_PAIRS-1:0]              IR_en,
    output logic signed [RES_W+NUM_PAIRS:0]   error,
    output logic                              err_vld,
    output logic                              busy,
    output logic                              a2d_to,
    output logic [2:0]                        state_dbg
);

    localparam int ERR_W  = RES_W + NUM_PAIRS + 1;
    localparam int PIDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [TCNT_W-1:0] TO_LAST     = TCNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CONV_R = 3'd2,
        WAIT_R = 3'd3,
        CONV_L = 3'd4,
        WAIT_L = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t                   state;
    logic [PIDX_W-1:0]        p;
    logic [NUM_PAIRS-1:0]     mask_q;
    logic [RES_W-1:0]         r_q;
    logic signed [ERR_W-1:0]  acc;
    logic [SCNT_W-1:0]        settle_cnt;
    logic [TCNT_W-1:0]        to_cnt;

    logic [PIDX_W:0]          first_pick;
    logic [PIDX_W:0]          next_pick;
    logic signed [RES_W:0]    diff;
    logic signed [ERR_W-1:0]  contrib;
    logic                     start_scan;
    logic [CHNL_W-1:0]        ch_r;
    logic [CHNL_W-1:0]        ch_l;

    assign state_dbg = state;

    // Returns {found, index} of the lowest unmasked pair at or above 'from'.
    function automatic logic [PIDX_W:0] find_unmasked(input logic [NUM_PAIRS-1:0] m,
                                                      input int from);
        logic [PIDX_W:0] pick;
        pick = '0;
        for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
            if (i >= from && !m[i]) pick = {1'b1, PIDX_W'(i)};
        end
        return pick;
    endfunction

    always_comb begin
        first_pick = find_unmasked(pair_mask, 0);
        next_pick  = find_unmasked(mask_q, int'(p) + 1);
        diff       = $signed({1'b0, r_q}) - $signed({1'b0, A2D_res});
        contrib    = ERR_W'(diff);
        contrib    = contrib <<< p;
        start_scan = (state == IDLE && scan) || (state == DONE && cont);
        ch_r       = CHNL_W'({p, 1'b0});
        ch_l       = CHNL_W'({p, 1'b1});
    end

    // A2D handshake: strt_cnv is a one-cycle request; the matching cnv_cmplt pulse
    // (with A2D_res valid in the same cycle) is accepted only in WAIT_R/WAIT_L,
    // so a completion coincident with strt_cnv or arriving while idle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            p          <= '0;
            mask_q     <= '0;
            r_q        <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            strt_cnv   <= 1'b0;
            chnnl      <= '0;
            IR_en      <= '0;
            error      <= '0;
            err_vld    <= 1'b0;
            busy       <= 1'b0;
            a2d_to     <= 1'b0;
        end else begin
            strt_cnv <= 1'b0;
            err_vld  <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan) a2d_to <= 1'b0;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= CONV_R;
                        strt_cnv <= 1'b1;
                        chnnl    <= ch_r;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CONV_R: begin
                    state  <= WAIT_R;
                    to_cnt <= '0;
                end
                WAIT_R: begin
                    if (cnv_cmplt) begin
                        r_q      <= A2D_res;
                        state    <= CONV_L;
                        strt_cnv <= 1'b1;
                        chnnl    <= ch_l;
                    end else if (to_cnt == TO_LAST) begin
                        a2d_to <= 1'b1;
                        state  <= NEXT;
                        IR_en  <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CONV_L: begin
                    state  <= WAIT_L;
                    to_cnt <= '0;
                end
                WAIT_L: begin
                    if (cnv_cmplt) begin
                        acc   <= acc + contrib;
                        state <= NEXT;
                        IR_en <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        // A timed-out pair contributes nothing to the error.
                        a2d_to <= 1'b1;
                        state  <= NEXT;
                        IR_en  <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (next_pick[PIDX_W]) begin
                        p          <= next_pick[PIDX_W-1:0];
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        IR_en      <= NUM_PAIRS'(1) << next_pick[PIDX_W-1:0];
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    error   <= acc;
                    err_vld <= 1'b1;
                    if (!cont) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // New scan, from IDLE or as a continuous-mode restart out of DONE.
            if (start_scan) begin
                mask_q <= pair_mask;
                acc    <= '0;
                busy   <= 1'b1;
                if (first_pick[PIDX_W]) begin
                    p          <= first_pick[PIDX_W-1:0];
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    IR_en      <= NUM_PAIRS'(1) << first_pick[PIDX_W-1:0];
                end else begin
                    state <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_scan_seq.sv
// Self-checking bench for ir_scan_seq: an A2D responder model, a monitor logging
// conversions / enables / err_vld pulses, and scenario tasks checked against a plain model.
module tb_ir_scan_seq;

    localparam int NP = 3;
    localparam int RW = 12;
    localparam int CW = 3;
    localparam int SC = 8;
    localparam int TO = 16;
    localparam int EW = RW + NP + 1;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 scan;
    logic                 cont;
    logic [NP-1:0]        pair_mask;
    logic                 cnv_cmplt;
    logic [RW-1:0]        A2D_res;
    logic                 strt_cnv;
    logic [CW-1:0]        chnnl;
    logic [NP-1:0]        IR_en;
    logic signed [EW-1:0] error;
    logic                 err_vld;
    logic                 busy;
    logic                 a2d_to;
    logic [2:0]           state_dbg;

    ir_scan_seq #(
        .NUM_PAIRS(NP), .RES_W(RW), .CHNL_W(CW), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .scan(scan), .cont(cont), .pair_mask(pair_mask),
        .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .IR_en(IR_en), .error(error), .err_vld(err_vld), .busy(busy), .a2d_to(a2d_to),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // A2D model configuration
    logic [RW-1:0] r_val [NP];
    logic [RW-1:0] l_val [NP];
    int            lat         = 5;
    int            suppress_ch = -1;

    // Observation logs
    logic [CW-1:0] chan_q [$];
    logic [NP-1:0] en_q [$];
    logic [CW-1:0] exp_q [$];
    int            vld_cyc [$];
    int            vld_cnt = 0;
    logic [NP-1:0] en_prev = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (strt_cnv) chan_q.push_back(chnnl);
            if (IR_en != en_prev && IR_en != '0) en_q.push_back(IR_en);
            en_prev = IR_en;
            if (err_vld) begin
                vld_cnt++;
                vld_cyc.push_back(cyc);
            end
        end
    end

    // A2D: answers each strt_cnv 'lat' cycles later unless the channel is suppressed.
    initial begin
        int ci;
        cnv_cmplt = 1'b0;
        A2D_res   = '0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (strt_cnv && !rst) begin
                ci = int'(chnnl);
                repeat (lat - 1) @(negedge clk);
                if (ci != suppress_ch) begin
                    A2D_res   = ci[0] ? l_val[ci >> 1] : r_val[ci >> 1];
                    cnv_cmplt = 1'b1;
                end
            end
        end
    end

    task automatic set_vals(input logic [RW-1:0] r, input logic [RW-1:0] l);
        for (int i = 0; i < NP; i++) begin
            r_val[i] = r;
            l_val[i] = l;
        end
    endtask

    task automatic do_scan(input logic [NP-1:0] m);
        int start;
        int waited;
        start = vld_cnt;
        waited = 0;
        chan_q.delete();
        en_q.delete();
        pair_mask = m;
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        while (vld_cnt == start && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (vld_cnt == start) begin
            n_fail++;
            $display("FAIL scan_done: no err_vld after %0d cycles, required one", waited);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 8;
        if (strt_cnv !== 1'b0) begin n_fail++; $display("FAIL rst_strt_cnv: got %b want 0", strt_cnv); end
        if (chnnl !== '0) begin n_fail++; $display("FAIL rst_chnnl: got %0d want 0", chnnl); end
        if (IR_en !== '0) begin n_fail++; $display("FAIL rst_IR_en: got %b want 0", IR_en); end
        if (error !== '0) begin n_fail++; $display("FAIL rst_error: got %0d want 0", error); end
        if (err_vld !== 1'b0) begin n_fail++; $display("FAIL rst_err_vld: got %b want 0", err_vld); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (a2d_to !== 1'b0) begin n_fail++; $display("FAIL rst_a2d_to: got %b want 0", a2d_to); end
        if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want IDLE", state_dbg); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int start;
        set_vals(12'h800, 12'h700);
        start = vld_cnt;
        do_scan(3'b000);
        n_checks += 4;
        if (error !== EW'(1792)) begin n_fail++; $display("FAIL basic_error: got %0d want 1792", error); end
        if (vld_cnt - start != 1) begin n_fail++; $display("FAIL basic_vld_count: got %0d want 1", vld_cnt - start); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
        if (chan_q.size() != 6 || en_q.size() != 3) begin
            n_fail++;
            $display("FAIL basic_seq_len: got %0d chans %0d enables want 6 and 3", chan_q.size(), en_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (chan_q[i] !== CW'(i)) begin n_fail++; $display("FAIL basic_chnnl[%0d]: got %0d want %0d", i, chan_q[i], i); end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (en_q[i] !== NP'(1 << i)) begin n_fail++; $display("FAIL basic_IR_en[%0d]: got %b want %b", i, en_q[i], NP'(1 << i)); end
            end
        end
    endtask

    task automatic test_mask();
        int hits_ch;
        int hits_en;
        set_vals(12'h800, 12'h700);
        do_scan(3'b010);
        hits_ch = 0;
        hits_en = 0;
        foreach (chan_q[i]) if (chan_q[i] == 3'd2 || chan_q[i] == 3'd3) hits_ch++;
        foreach (en_q[i]) if (en_q[i] == 3'b010) hits_en++;
        n_checks += 4;
        if (error !== EW'(1280)) begin n_fail++; $display("FAIL mask_error: got %0d want 1280", error); end
        if (hits_ch != 0) begin n_fail++; $display("FAIL mask_chnnl23: got %0d conversions want 0", hits_ch); end
        if (hits_en != 0) begin n_fail++; $display("FAIL mask_IR_en010: got %0d occurrences want 0", hits_en); end
        if (chan_q.size() != 4) begin n_fail++; $display("FAIL mask_conv_count: got %0d want 4", chan_q.size()); end
    endtask

    task automatic test_negative();
        set_vals(12'h000, 12'hFFF);
        do_scan(3'b000);
        n_checks++;
        if (error !== EW'(-28665)) begin n_fail++; $display("FAIL neg_error: got %0d want -28665", error); end
    endtask

    task automatic test_cont();
        int start;
        int c0;
        int waited;
        set_vals(12'h800, 12'h700);
        start = vld_cnt;
        c0 = vld_cyc.size();
        cont = 1'b1;
        pair_mask = 3'b000;
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        waited = 0;
        while (vld_cnt == start && waited < 1000) begin @(negedge clk); waited++; end
        cont = 1'b0;
        while (vld_cnt < start + 2 && waited < 1000) begin @(negedge clk); waited++; end
        repeat (5) @(negedge clk);
        n_checks += 4;
        if (vld_cnt - start != 2) begin
            n_fail++;
            $display("FAIL cont_vld_count: got %0d want 2", vld_cnt - start);
        end else if (vld_cyc[c0 + 1] - vld_cyc[c0] != NP * (SC + 2 * lat + 1) + 1) begin
            n_fail++;
            $display("FAIL cont_period: got %0d want %0d", vld_cyc[c0 + 1] - vld_cyc[c0], NP * (SC + 2 * lat + 1) + 1);
        end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_busy: got %b want 0", busy); end
        if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL cont_state: got %0d want IDLE", state_dbg); end
        if (error !== EW'(1792)) begin n_fail++; $display("FAIL cont_error: got %0d want 1792", error); end
    endtask

    task automatic test_timeout();
        set_vals(12'h800, 12'h700);
        suppress_ch = 3;
        do_scan(3'b000);
        n_checks += 3;
        if (a2d_to !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", a2d_to); end
        if (error !== EW'(1280)) begin n_fail++; $display("FAIL to_error: got %0d want 1280", error); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
        suppress_ch = -1;
        do_scan(3'b000);
        n_checks += 2;
        if (a2d_to !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", a2d_to); end
        if (error !== EW'(1792)) begin n_fail++; $display("FAIL to_recover_error: got %0d want 1792", error); end
    endtask

    task automatic test_rst_mid();
        int waited;
        set_vals(12'h800, 12'h700);
        pair_mask = 3'b000;
        scan = 1'b1;
        @(negedge clk);
        scan = 1'b0;
        waited = 0;
        while (!(strt_cnv && chnnl == 3'd3) && waited < 500) begin @(negedge clk); waited++; end
        n_checks++;
        if (waited >= 500) begin n_fail++; $display("FAIL rstmid_reach: no channel 3 conversion in %0d cycles", waited); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 8;
        if (strt_cnv !== 1'b0) begin n_fail++; $display("FAIL rstmid_strt_cnv: got %b want 0", strt_cnv); end
        if (chnnl !== '0) begin n_fail++; $display("FAIL rstmid_chnnl: got %0d want 0", chnnl); end
        if (IR_en !== '0) begin n_fail++; $display("FAIL rstmid_IR_en: got %b want 0", IR_en); end
        if (error !== '0) begin n_fail++; $display("FAIL rstmid_error: got %0d want 0", error); end
        if (err_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_vld: got %b want 0", err_vld); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (a2d_to !== 1'b0) begin n_fail++; $display("FAIL rstmid_a2d_to: got %b want 0", a2d_to); end
        if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want IDLE", state_dbg); end
        @(negedge clk);
        n_checks++;
        if (strt_cnv !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_strt: got %b want 0", strt_cnv); end
        repeat (20) @(negedge clk);
        do_scan(3'b000);
        n_checks += 2;
        if (error !== EW'(1792)) begin n_fail++; $display("FAIL rstmid_rescan_error: got %0d want 1792", error); end
        if (chan_q.size() != 6) begin n_fail++; $display("FAIL rstmid_rescan_convs: got %0d want 6", chan_q.size()); end
    endtask

    task automatic test_random();
        logic [NP-1:0] m;
        int exp_err;
        logic exp_to;
        for (int it = 0; it < 8; it++) begin
            m = NP'($urandom_range(0, (1 << NP) - 1));
            lat = $urandom_range(2, 8);
            suppress_ch = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * NP - 1) : -1;
            for (int i = 0; i < NP; i++) begin
                r_val[i] = RW'($urandom_range(0, 4095));
                l_val[i] = RW'($urandom_range(0, 4095));
            end
            exp_err = 0;
            exp_to = 1'b0;
            exp_q.delete();
            for (int i = 0; i < NP; i++) begin
                if (!m[i]) begin
                    exp_q.push_back(CW'(2 * i));
                    if (suppress_ch != 2 * i) exp_q.push_back(CW'(2 * i + 1));
                    if (suppress_ch == 2 * i || suppress_ch == 2 * i + 1) exp_to = 1'b1;
                    else exp_err += (int'(r_val[i]) - int'(l_val[i])) * (1 << i);
                end
            end
            do_scan(m);
            n_checks += 3;
            if (error !== EW'(exp_err)) begin n_fail++; $display("FAIL rand%0d_error: got %0d want %0d", it, error, exp_err); end
            if (a2d_to !== exp_to) begin n_fail++; $display("FAIL rand%0d_a2d_to: got %b want %b", it, a2d_to, exp_to); end
            if (chan_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_conv_count: got %0d want %0d", it, chan_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (chan_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_chnnl[%0d]: got %0d want %0d", it, i, chan_q[i], exp_q[i]); end
                end
            end
        end
        lat = 5;
        suppress_ch = -1;
    endtask

    initial begin
        rst = 1'b1;
        scan = 1'b0;
        cont = 1'b0;
        pair_mask = '0;
        set_vals(12'h800, 12'h700);
        test_reset();
        test_basic();
        test_mask();
        test_negative();
        test_cont();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_scan_seq.md
Name: ir_scan_seq

Overview:
- Parametrised successor to the fixed three-pair IR round-robin sequencing inside the motion controller.
- Sequences NUM_PAIRS left/right IR sensor pairs through the shared A2D: enable pair, settle, convert right, convert left, then move to the next pair.
- Accumulates a weighted, signed line-position error and hands it to the PI/motor stage with a one-cycle valid pulse.
- Adds two behaviours the fixed block lacks: per-pair masking and continuous/single-shot scan modes.

Parameters:
- NUM_PAIRS, 3, number of IR sensor pairs (1..4).
- RES_W, 12, A2D result width.
- CHNL_W, 3, A2D channel select width; 2*NUM_PAIRS must be ≤ 2**CHNL_W.
- SETTLE_CYC, 4096, cycles the pair enable is held before the first conversion (≥2).
- TIMEOUT_CYC, 1024, maximum cycles to wait for cnv_cmplt.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- scan  in  1  start request; sampled in IDLE only.
- cont  in  1  1 = rescan automatically after DONE; sampled at DONE.
- pair_mask  in  NUM_PAIRS  1 = skip pair p; sampled at scan start.
- cnv_cmplt  in  1  A2D conversion complete, 1-cycle pulse.
- A2D_res  in  RES_W  A2D result, valid while cnv_cmplt=1.
- strt_cnv  out  1  1-cycle conversion start pulse.
- chnnl  out  CHNL_W  channel under conversion.
- IR_en  out  NUM_PAIRS  one-hot enable of the active pair.
- error  out  RES_W+NUM_PAIRS+1  signed weighted error, held between scans.
- err_vld  out  1  1-cycle pulse when error updates.
- busy  out  1  high outside IDLE.
- a2d_to  out  1  sticky timeout flag; cleared only by rst or a new scan from IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0; pair index 0. Reset is honoured in any state, including mid-conversion. strt_cnv never pulses in the cycle after rst.
- States: IDLE, SETTLE, CONV_R, WAIT_R, CONV_L, WAIT_L, NEXT, DONE.
- IDLE:
  - On scan=1: latch pair_mask, clear accumulator and a2d_to, select the first unmasked pair p.
  - If every pair is masked, go straight to DONE.
  - Otherwise go to SETTLE with the settle counter at 0.
- SETTLE: IR_en[p]=1. After SETTLE_CYC cycles, go to CONV_R.
- CONV_R: one cycle; strt_cnv=1, chnnl=2p. Go to WAIT_R.
- WAIT_R: chnnl holds 2p. On cnv_cmplt, capture A2D_res as R and go to CONV_L.
- CONV_L: one cycle; strt_cnv=1, chnnl=2p+1. Go to WAIT_L.
- WAIT_L: chnnl holds 2p+1. On cnv_cmplt, acc += (R − A2D_res) << p and go to NEXT.
  - The difference is computed as a signed RES_W+1 value.
  - Pair weight is 2**p; the error width guarantees no overflow.
- Timeout: cnv_cmplt absent for TIMEOUT_CYC cycles in WAIT_R or WAIT_L:
  - Set a2d_to.
  - Treat the pair's contribution as 0.
  - Go to NEXT.
- IR_en[p] stays high from SETTLE through WAIT_L and drops in NEXT.
- NEXT: advance p to the next unmasked pair.
  - If one exists, go to SETTLE; the enable rises in the following cycle.
  - If not, go to DONE.
- DONE: one cycle.
  - error <= acc, err_vld=1.
  - If cont=1, restart exactly as a scan from IDLE, re-sampling pair_mask but not clearing a2d_to. Otherwise go to IDLE.
- A cnv_cmplt outside WAIT_R/WAIT_L is ignored.
- A cnv_cmplt in the same cycle as strt_cnv is ignored.
- scan is ignored while busy.

Test Plan:
- NUM_PAIRS=3, SETTLE_CYC=8, mask=000. Bench returns 0x800 on even channels and 0x700 on odd, 5 cycles after strt_cnv.
  -> error = 0x100·7 = 1792.
  -> chnnl sequence 0,1,2,3,4,5.
  -> IR_en sequence 001, 010, 100.
  -> exactly one err_vld.
- Same stimulus, mask=010.
  -> error = 1280.
  -> channels 2 and 3 never converted.
  -> IR_en never equals 010.
- Right=0x000, left=0xFFF on all pairs.
  -> error = −4095·7 = −28665, with no wrap.
- cont=1 held: two consecutive err_vld pulses, separated by exactly one scan length.
  -> Drop cont to 0 before the second DONE -> returns to IDLE, busy=0.
- Suppress cnv_cmplt on channel 3 with TIMEOUT_CYC=16.
  -> a2d_to=1.
  -> error = 0x100·5 = 1280.
  -> scan completes.
- Assert rst during WAIT_L of pair 1.
  -> next cycle: all outputs 0, state IDLE.
  -> a later scan produces a correct, full result.
